// File: rtl/camera_pixel_capture.sv
// Camera byte-stream capture: pairs RGB565 high/low bytes into pixels,
// tracks raster position and flags lines of the wrong length.
module camera_pixel_capture #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic        cam_byte_en,
    input  logic [7:0]  cam_data,
    output logic [15:0] pixel_out,
    output logic        data_valid_out,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err
);

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        IDLE_LINE = 2'd1,
        HI_BYTE   = 2'd2,
        LO_BYTE   = 2'd3
    } state_t;

    localparam logic [9:0] W_LIM = 10'(IMG_WIDTH);
    localparam logic [9:0] H_LIM = 10'(IMG_HEIGHT);

    state_t      state_r;
    state_t      next_state_s;
    logic        vsync_d_r;
    logic        href_d_r;
    logic [7:0]  hi_byte_r;
    logic [9:0]  x_cnt_r;
    logic [9:0]  y_cnt_r;
    logic        over_r;

    logic        vsync_fall_s;
    logic        href_fall_s;
    logic        byte_s;
    logic        last_line_s;
    logic        start_s;
    logic        abort_s;
    logic        close_s;
    logic        hi_cap_s;
    logic        lo_cap_s;
    logic        col_ok_s;
    logic        row_ok_s;
    logic        pix_fire_s;
    logic        done_s;
    logic        len_bad_s;

    assign vsync_fall_s = vsync_d_r & ~cam_vsync;
    assign href_fall_s  = href_d_r & ~cam_href;
    assign byte_s       = cam_href & cam_byte_en;
    assign last_line_s  = (y_cnt_r >= (H_LIM - 10'd1));

    // Edge-detect history for vsync and href
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d_r <= 1'b0;
            href_d_r  <= 1'b0;
        end else begin
            vsync_d_r <= cam_vsync;
            href_d_r  <= cam_href;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= SYNC;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; vsync high aborts any in-frame state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            SYNC: begin
                if (vsync_fall_s) next_state_s = IDLE_LINE;
                else              next_state_s = SYNC;
            end
            IDLE_LINE: begin
                if (cam_vsync)   next_state_s = SYNC;
                else if (byte_s) next_state_s = LO_BYTE;
                else             next_state_s = IDLE_LINE;
            end
            HI_BYTE: begin
                if (cam_vsync)        next_state_s = SYNC;
                else if (href_fall_s) next_state_s = last_line_s ? SYNC : IDLE_LINE;
                else if (byte_s)      next_state_s = LO_BYTE;
                else                  next_state_s = HI_BYTE;
            end
            LO_BYTE: begin
                if (cam_vsync)        next_state_s = SYNC;
                else if (href_fall_s) next_state_s = last_line_s ? SYNC : IDLE_LINE;
                else if (byte_s)      next_state_s = HI_BYTE;
                else                  next_state_s = LO_BYTE;
            end
            default: next_state_s = SYNC;
        endcase
    end

    // Per-cycle control strobes decoded from state and inputs
    always_comb begin
        start_s  = 1'b0;
        abort_s  = 1'b0;
        close_s  = 1'b0;
        hi_cap_s = 1'b0;
        lo_cap_s = 1'b0;
        case (state_r)
            SYNC: begin
                start_s = vsync_fall_s;
            end
            IDLE_LINE: begin
                abort_s  = cam_vsync;
                hi_cap_s = ~cam_vsync & byte_s;
            end
            HI_BYTE: begin
                abort_s  = cam_vsync;
                close_s  = ~cam_vsync & href_fall_s;
                hi_cap_s = ~cam_vsync & byte_s;
            end
            LO_BYTE: begin
                abort_s  = cam_vsync;
                close_s  = ~cam_vsync & href_fall_s;
                lo_cap_s = ~cam_vsync & byte_s;
            end
            default: begin
                start_s = 1'b0;
            end
        endcase
        col_ok_s   = (x_cnt_r < W_LIM);
        row_ok_s   = (y_cnt_r < H_LIM);
        pix_fire_s = lo_cap_s & col_ok_s & row_ok_s;
        done_s     = close_s & last_line_s;
        // over_r catches lines that ran past the saturated column count
        len_bad_s  = close_s & ((x_cnt_r != W_LIM) | over_r);
    end

    // Column/line counters and high-byte holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_byte_r <= 8'd0;
            x_cnt_r   <= 10'd0;
            y_cnt_r   <= 10'd0;
            over_r    <= 1'b0;
        end else begin
            if (hi_cap_s) hi_byte_r <= cam_data;
            else          hi_byte_r <= hi_byte_r;

            if (start_s | close_s | abort_s) begin
                x_cnt_r <= 10'd0;
                over_r  <= 1'b0;
            end else if (lo_cap_s & col_ok_s) begin
                x_cnt_r <= x_cnt_r + 10'd1;
                over_r  <= over_r;
            end else if (lo_cap_s) begin
                x_cnt_r <= x_cnt_r;
                over_r  <= 1'b1;
            end else begin
                x_cnt_r <= x_cnt_r;
                over_r  <= over_r;
            end

            if (start_s)                 y_cnt_r <= 10'd0;
            else if (close_s & row_ok_s) y_cnt_r <= y_cnt_r + 10'd1;
            else                         y_cnt_r <= y_cnt_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_out      <= 16'd0;
            data_valid_out <= 1'b0;
            x_pos          <= 10'd0;
            y_pos          <= 10'd0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            line_err       <= 1'b0;
        end else begin
            data_valid_out <= pix_fire_s;
            frame_start    <= start_s;
            frame_done     <= done_s;
            if (pix_fire_s) begin
                pixel_out <= {hi_byte_r, cam_data};
                x_pos     <= x_cnt_r;
                y_pos     <= y_cnt_r;
            end else begin
                pixel_out <= pixel_out;
                x_pos     <= x_pos;
                y_pos     <= y_pos;
            end
            if (start_s)        line_err <= 1'b0;
            else if (len_bad_s) line_err <= 1'b1;
            else                line_err <= line_err;
        end
    end

endmodule

// File: tb/tb_camera_pixel_capture.sv
// Randomized bench for camera_pixel_capture: a frame/line/byte-index model
// predicts every output cycle; literal checks pin key scenarios.
module tb_camera_pixel_capture;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int MAXC = 30000;

    logic        clk;
    logic        rst;
    logic        cam_vsync;
    logic        cam_href;
    logic        cam_byte_en;
    logic [7:0]  cam_data;
    logic [15:0] pixel_out;
    logic        data_valid_out;
    logic [9:0]  x_pos;
    logic [9:0]  y_pos;
    logic        frame_start;
    logic        frame_done;
    logic        line_err;

    camera_pixel_capture #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_byte_en(cam_byte_en), .cam_data(cam_data), .pixel_out(pixel_out),
        .data_valid_out(data_valid_out), .x_pos(x_pos), .y_pos(y_pos),
        .frame_start(frame_start), .frame_done(frame_done), .line_err(line_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    bit        exp_v  [MAXC];
    bit [15:0] exp_pix[MAXC];
    bit [9:0]  exp_x  [MAXC];
    bit [9:0]  exp_y  [MAXC];
    bit        exp_fs [MAXC];
    bit        exp_fd [MAXC];
    bit        exp_le [MAXC];

    // model: frame active flag, line index, accepted-byte count in line
    bit       m_active = 1'b0;
    bit       m_pv = 1'b0;
    bit       m_ph = 1'b0;
    bit       m_le = 1'b0;
    int       m_line = 0;
    int       m_nb = 0;
    bit [7:0] m_hb = 8'd0;
    bit       first_f800 = 1'b0;

    // observations gathered by the compare process
    int        n_valid = 0;
    int        n_fd = 0;
    int        max_x = 0;
    bit        got_first = 1'b0;
    bit [15:0] first_pix = 16'd0;
    bit [9:0]  first_x = 10'd0;
    bit [9:0]  first_y = 10'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (cyc > 0 && cyc < MAXC) begin
            chk("data_valid_out", data_valid_out, exp_v[cyc]);
            chk("frame_start", frame_start, exp_fs[cyc]);
            chk("frame_done", frame_done, exp_fd[cyc]);
            chk("line_err", line_err, exp_le[cyc]);
            if (exp_v[cyc]) begin
                chk("pixel_out", pixel_out, exp_pix[cyc]);
                chk("x_pos", x_pos, exp_x[cyc]);
                chk("y_pos", y_pos, exp_y[cyc]);
            end
        end
        if (frame_start) begin
            got_first = 1'b0;
            max_x = 0;
        end
        if (data_valid_out) begin
            n_valid++;
            if (int'(x_pos) > max_x) max_x = int'(x_pos);
            if (!got_first) begin
                got_first = 1'b1;
                first_pix = pixel_out;
                first_x = x_pos;
                first_y = y_pos;
            end
        end
        if (frame_done) n_fd++;
    end

    // Drive one cycle of inputs and record what the next edge must produce.
    task automatic step(input logic v, input logic h, input logic be, input logic [7:0] d);
        int  n;
        bit  vfall;
        bit  hfall;
        bit  e_v;
        bit  e_fs;
        bit  e_fd;
        bit [15:0] e_pix;
        bit [9:0]  e_x;
        bit [9:0]  e_y;
        cam_vsync = v; cam_href = h; cam_byte_en = be; cam_data = d;
        n = cyc + 1;
        e_v = 1'b0; e_fs = 1'b0; e_fd = 1'b0; e_pix = 16'd0; e_x = 10'd0; e_y = 10'd0;
        if (rst) begin
            m_active = 1'b0; m_pv = 1'b0; m_ph = 1'b0; m_le = 1'b0;
        end else begin
            vfall = m_pv & ~v;
            hfall = m_ph & ~h;
            if (!m_active) begin
                if (vfall) begin
                    m_active = 1'b1; m_line = 0; m_nb = 0; m_le = 1'b0; e_fs = 1'b1;
                end
            end else if (v) begin
                m_active = 1'b0;
            end else if (hfall && m_nb > 0) begin
                if (m_nb / 2 != W) m_le = 1'b1;
                m_line++;
                m_nb = 0;
                if (m_line == H) begin
                    e_fd = 1'b1;
                    m_active = 1'b0;
                end
            end else if (h && be) begin
                if (m_nb % 2 == 1) begin
                    if (m_nb / 2 < W && m_line < H) begin
                        e_v = 1'b1; e_pix = {m_hb, d};
                        e_x = 10'(m_nb / 2); e_y = 10'(m_line);
                    end
                end else begin
                    m_hb = d;
                end
                m_nb++;
            end
            m_pv = v;
            m_ph = h;
        end
        if (n < MAXC) begin
            exp_v[n] = e_v; exp_pix[n] = e_pix; exp_x[n] = e_x; exp_y[n] = e_y;
            exp_fs[n] = e_fs; exp_fd[n] = e_fd; exp_le[n] = m_le;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_line(input int line, input int npix, input int extra, input int mode);
        int nb;
        logic [15:0] p;
        logic [7:0] b;
        nb = 2 * npix + extra;
        for (int i = 0; i < nb; i++) begin
            if (mode == 1) begin
                if (first_f800 && line == 0 && i < 2) p = 16'hF800;
                else p = 16'(line * W + i / 2);
                b = (i % 2 == 0) ? p[15:8] : p[7:0];
            end else begin
                b = 8'($urandom);
            end
            repeat ($urandom_range(0, 2)) step(1'b0, 1'b1, 1'b0, 8'($urandom));
            step(1'b0, 1'b1, 1'b1, b);
        end
        // href falls, possibly with a simultaneous strobe that must be ignored
        step(1'b0, 1'b0, 1'($urandom % 2), 8'($urandom));
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'($urandom % 2), 8'($urandom));
    endtask

    task automatic send_frame(input int short_line, input int long_line, input int abort_line, input int mode);
        int npix;
        int extra;
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("frame_start_on_vsync_fall", frame_start, 1'b1);
        chk("line_err_cleared_at_start", line_err, 1'b0);
        for (int ln = 0; ln < H; ln++) begin
            if (ln == abort_line) begin
                step(1'b0, 1'b1, 1'b1, 8'h11);
                step(1'b0, 1'b1, 1'b1, 8'h22);
                step(1'b0, 1'b1, 1'b1, 8'h33);
                step(1'b1, 1'b1, 1'b1, 8'h44);
                step(1'b1, 1'b0, 1'b0, 8'd0);
                return;
            end
            npix = W;
            extra = 0;
            if (ln == short_line) npix = W - 1;
            if (ln == long_line) npix = W + 2;
            if (mode == 2) begin
                if ($urandom % 4 == 0) npix = $urandom_range(W - 1, W + 1);
                extra = $urandom % 2;
            end
            send_line(ln, npix, extra, mode);
        end
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    int v0;
    int f0;

    initial begin
        rst = 1'b1;
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("reset_pixel_out", pixel_out, 16'd0);
        chk("reset_valid", data_valid_out, 1'b0);
        chk("reset_x_pos", x_pos, 10'd0);
        chk("reset_y_pos", y_pos, 10'd0);
        chk("reset_frame_start", frame_start, 1'b0);
        chk("reset_frame_done", frame_done, 1'b0);
        chk("reset_line_err", line_err, 1'b0);
        rst = 1'b0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);

        // full frame of counting pixels, first pixel F8/00
        first_f800 = 1'b1;
        v0 = n_valid; f0 = n_fd;
        send_frame(-1, -1, -1, 1);
        first_f800 = 1'b0;
        chk("full_frame_pixels", n_valid - v0, W * H);
        chk("full_frame_done_count", n_fd - f0, 1);
        chk("full_frame_line_err", line_err, 1'b0);
        chk("first_pixel_value", first_pix, 16'hF800);
        chk("first_pixel_x", first_x, 10'd0);
        chk("first_pixel_y", first_y, 10'd0);

        // line 5 one pixel short
        v0 = n_valid; f0 = n_fd;
        send_frame(5, -1, -1, 1);
        chk("short_line_pixels", n_valid - v0, W * H - 1);
        chk("short_line_err", line_err, 1'b1);
        chk("short_line_done_count", n_fd - f0, 1);

        // line 2 two pixels too long
        v0 = n_valid;
        send_frame(-1, 2, -1, 1);
        chk("long_line_pixels", n_valid - v0, W * H);
        chk("long_line_max_x", max_x, W - 1);
        chk("long_line_err", line_err, 1'b1);

        // vsync aborts mid-line 4
        v0 = n_valid; f0 = n_fd;
        send_frame(-1, -1, 4, 1);
        chk("abort_no_frame_done", n_fd - f0, 0);
        chk("abort_pixels", n_valid - v0, 4 * W + 1);
        f0 = n_fd;
        send_frame(-1, -1, -1, 1);
        chk("after_abort_first_y", first_y, 10'd0);
        chk("after_abort_done_count", n_fd - f0, 1);

        // reset between high and low byte
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b1, 8'hA5);
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b1, 1'b1, 8'h3C);
        rst = 1'b1;
        #1;
        chk("midline_reset_pixel_out", pixel_out, 16'd0);
        chk("midline_reset_valid", data_valid_out, 1'b0);
        chk("midline_reset_x_pos", x_pos, 10'd0);
        chk("midline_reset_y_pos", y_pos, 10'd0);
        chk("midline_reset_line_err", line_err, 1'b0);
        if (cyc < MAXC) begin
            exp_v[cyc] = 1'b0; exp_fs[cyc] = 1'b0; exp_fd[cyc] = 1'b0; exp_le[cyc] = 1'b0;
        end
        v0 = n_valid;
        step(1'b0, 1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 1'b0, 8'd0);
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1, 8'hC3);
        repeat (6) step(1'b0, 1'b1, 1'b1, 8'($urandom));
        step(1'b0, 1'b0, 1'b0, 8'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);
        chk("no_pixels_before_vsync_fall", n_valid - v0, 0);

        send_frame(-1, -1, -1, 1);
        for (int k = 0; k < 6; k++) send_frame(-1, -1, ($urandom % 4 == 0) ? 3 : -1, 2);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/camera_pixel_capture.md
CAMERA_PIXEL_CAPTURE -- requirements
Module: camera_pixel_capture

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 640, active pixels per line.
REQ-002 SHALL have parameter IMG_HEIGHT, default 480, active lines per frame.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cam_vsync  input  1  camera frame sync; high = vertical blanking.
REQ-006 SHALL have port cam_href  input  1  camera line-active qualifier.
REQ-007 SHALL have port cam_byte_en  input  1  one-cycle strobe: cam_data holds a new byte.
REQ-008 SHALL have port cam_data  input  8  camera byte, RGB565, high byte first.
REQ-009 SHALL have port pixel_out  output  16  assembled RGB565 pixel.
REQ-010 SHALL have port data_valid_out  output  1  one-cycle pulse: pixel_out valid.
REQ-011 SHALL have port x_pos  output  10  column of current pixel_out.
REQ-012 SHALL have port y_pos  output  10  line of current pixel_out.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse at start of an accepted frame.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a complete frame.
REQ-015 SHALL have port line_err  output  1  sticky per frame: a line had length != IMG_WIDTH.

Function
REQ-016 SHALL implement states SYNC, IDLE_LINE, HI_BYTE, LO_BYTE.
REQ-017 SYNC: SHALL wait for a cam_vsync falling edge (registered 1->0), then go to IDLE_LINE, pulse frame_start, clear line counter and line_err.
REQ-018 IDLE_LINE: on cam_href=1 with cam_byte_en=1, SHALL capture cam_data as high byte and go to LO_BYTE; otherwise stay.
REQ-019 HI_BYTE: on cam_byte_en=1 with cam_href=1, SHALL capture high byte and go to LO_BYTE.
REQ-020 LO_BYTE: on cam_byte_en=1 with cam_href=1, SHALL form {high,cam_data} and go to HI_BYTE.
REQ-021 Pixel SHALL appear on pixel_out with data_valid_out=1 exactly one cycle after the low-byte strobe; data_valid_out=0 otherwise.
REQ-022 x_pos/y_pos SHALL accompany each pixel; x_pos counts 0..IMG_WIDTH-1 within a line.
REQ-023 Pixels with column >= IMG_WIDTH SHALL be dropped (no valid pulse), and column count saturates at IMG_WIDTH.
REQ-024 Lines with index >= IMG_HEIGHT SHALL be dropped entirely.
REQ-025 On href falling edge (from HI_BYTE or LO_BYTE): SHALL discard any unpaired high byte, set line_err if column count != IMG_WIDTH, increment line counter, return to IDLE_LINE.
REQ-026 When the line counter reaches IMG_HEIGHT on an href falling edge, SHALL pulse frame_done the following cycle and go to SYNC.
REQ-027 cam_vsync=1 in any state other than SYNC SHALL abort the frame: go to SYNC, no frame_done, partial pixel discarded.
REQ-028 cam_byte_en while cam_href=0 SHALL be ignored.
REQ-029 Href-fall and byte strobe in the same cycle: the byte SHALL be ignored, the line is closed.
REQ-030 line_err SHALL hold until the next frame_start.
REQ-031 Counters SHALL be 10-bit unsigned; no wrap beyond stated saturation.

Reset
REQ-032 On rst=1, SHALL immediately enter SYNC; pixel_out=0, data_valid_out=0, x_pos=0, y_pos=0, frame_start=0, frame_done=0, line_err=0, edge registers cleared.
REQ-033 Reset asserted mid-line SHALL discard all partial state; capture resumes only after the next vsync falling edge.

Verification
REQ-034 Bytes 0xF8,0x00 on line 0 after vsync fall -> one pulse, pixel_out=16'hF800, x_pos=0, y_pos=0, one cycle after second strobe.
REQ-035 Full 640x480 frame of counting pixels -> 307200 valid pulses, coordinates raster-ordered, single frame_done, line_err=0.
REQ-036 Line 5 with 639 pixels, then a full frame -> line_err=1 from line 5 end until next frame_start; the 639 pixels still delivered.
REQ-037 Line with 642 pixels -> only 640 valid pulses, x_pos max 639, line_err=1.
REQ-038 vsync rises at line 100 -> no frame_done; next frame starts at y_pos=0 with frame_start pulse.
REQ-039 rst pulsed between high and low byte -> no valid pulse; outputs zero; no pixels until next vsync falling edge.
